// File: rtl/present_key_rev.sv
// present_key_rev: PRESENT-80 reverse key scheduler, emits round keys K32..K1
// from the final key-register state, one key per valid/ready transfer.
`default_nettype none

module present_key_rev (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [79:0] i_key_last,
    input  logic        i_rk_ready,
    output logic [63:0] o_rk,
    output logic        o_rk_valid,
    output logic [5:0]  o_rk_round,
    output logic        o_busy,
    output logic        o_done
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [79:0] r_kreg,  w_kreg_nxt;
    logic [4:0]  r_cnt,   w_cnt_nxt;
    logic        r_done,  w_done_nxt;

    logic [79:0] w_xor;
    logic [79:0] w_sub;
    logic [79:0] w_inv;

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;
            4'h1: y = 4'hE;
            4'h2: y = 4'hF;
            4'h3: y = 4'h8;
            4'h4: y = 4'hC;
            4'h5: y = 4'h1;
            4'h6: y = 4'h2;
            4'h7: y = 4'hD;
            4'h8: y = 4'hB;
            4'h9: y = 4'h4;
            4'hA: y = 4'h6;
            4'hB: y = 4'h3;
            4'hC: y = 4'h0;
            4'hD: y = 4'h7;
            4'hE: y = 4'h9;
            default: y = 4'hA;
        endcase
        return y;
    endfunction

    // Forward update is rotl61, S-box top nibble, XOR counter; undo in reverse order.
    assign w_xor = r_kreg ^ {60'd0, r_cnt, 15'd0};
    assign w_sub = {inv_sbox(w_xor[79:76]), w_xor[75:0]};
    assign w_inv = {w_sub[60:0], w_sub[79:61]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_kreg  <= 80'd0;
            r_cnt   <= 5'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_kreg  <= w_kreg_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_kreg_nxt  = r_kreg;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        if (i_abort) begin
            w_state_nxt = S_IDLE;
            w_kreg_nxt  = 80'd0;
            w_cnt_nxt   = 5'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        w_state_nxt = S_RUN;
                        w_kreg_nxt  = i_key_last;
                        w_cnt_nxt   = 5'd31;
                    end
                end
                S_RUN: begin
                    if (i_rk_ready) begin
                        if (r_cnt != 5'd0) begin
                            w_kreg_nxt = w_inv;
                            w_cnt_nxt  = r_cnt - 5'd1;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign o_rk       = r_kreg[79:16];
    assign o_rk_valid = (r_state == S_RUN);
    assign o_busy     = (r_state == S_RUN);
    assign o_rk_round = {1'b0, r_cnt} + 6'd1;
    assign o_done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_present_key_rev.sv
// tb_present_key_rev: directed checks of the reverse key scheduler against a
// forward PRESENT-80 key-schedule model.
`default_nettype none

module tb_present_key_rev;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic [79:0] i_key_last = '0;
    logic        i_rk_ready = 1'b0;
    logic [63:0] o_rk;
    logic        o_rk_valid;
    logic [5:0]  o_rk_round;
    logic        o_busy;
    logic        o_done;

    int total = 0;
    int bad   = 0;

    logic [79:0] st [0:31];

    typedef struct {
        logic [79:0] master;
        logic [63:0] rk1;
        logic [63:0] rk2;
        bit          chk2;
        bit          rnd;
    } vec_t;

    present_key_rev dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_abort    (i_abort),
        .i_key_last (i_key_last),
        .i_rk_ready (i_rk_ready),
        .o_rk       (o_rk),
        .o_rk_valid (o_rk_valid),
        .o_rk_round (o_rk_round),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC; 4'h1: y = 4'h5; 4'h2: y = 4'h6; 4'h3: y = 4'hB;
            4'h4: y = 4'h9; 4'h5: y = 4'h0; 4'h6: y = 4'hA; 4'h7: y = 4'hD;
            4'h8: y = 4'h3; 4'h9: y = 4'hE; 4'hA: y = 4'hF; 4'hB: y = 4'h8;
            4'hC: y = 4'h4; 4'hD: y = 4'h7; 4'hE: y = 4'h1; default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [79:0] fwd(input logic [79:0] k, input logic [4:0] i);
        logic [79:0] t;
        t = {k[18:0], k[79:19]};
        t[79:76] = sbox(t[79:76]);
        t[19:15] = t[19:15] ^ i;
        return t;
    endfunction

    task automatic build(input logic [79:0] master);
        st[0] = master;
        for (int i = 1; i < 32; i++) st[i] = fwd(st[i-1], 5'(i));
    endtask

    task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_rk"},    80'(o_rk),       80'd0);
        check({nm, "_valid"}, 80'(o_rk_valid), 80'd0);
        check({nm, "_round"}, 80'(o_rk_round), 80'd1);
        check({nm, "_busy"},  80'(o_busy),     80'd0);
        check({nm, "_done"},  80'(o_done),     80'd0);
    endtask

    // Load the model's final state, then walk K32..K1 with optional stall,
    // injected start at round inj_start, or abort at round abort_at.
    task automatic run_seq(input logic [79:0] master, input bit rnd, input int inj_start,
                           input int abort_at, input logic [79:0] alt_kl,
                           output logic [63:0] got_rk1, output logic [63:0] got_rk2);
        int r;
        int budget;
        bit rdy;
        got_rk1 = '0;
        got_rk2 = '0;
        build(master);
        @(negedge clk);
        i_key_last = st[31];
        i_start    = 1'b1;
        @(negedge clk);
        i_start    = 1'b0;
        i_key_last = '0;
        check("lat_round", 80'(o_rk_round), 80'd32);
        r = 32;
        budget = 0;
        while (r >= 1 && budget < 400) begin
            budget++;
            check("valid",   80'(o_rk_valid), 80'd1);
            check("busy",    80'(o_busy),     80'd1);
            check("no_done", 80'(o_done),     80'd0);
            check("rk",      80'(o_rk),       80'(st[r-1][79:16]));
            check("round",   80'(o_rk_round), 80'(r));
            if (abort_at == r) begin
                i_abort    = 1'b1;
                i_rk_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                i_abort    = 1'b0;
                i_rk_ready = 1'b0;
                check("abort_valid", 80'(o_rk_valid), 80'd0);
                check("abort_busy",  80'(o_busy),     80'd0);
                check("abort_done",  80'(o_done),     80'd0);
                @(negedge clk);
                check("abort_done2", 80'(o_done),     80'd0);
                return;
            end
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            i_rk_ready = rdy;
            if (inj_start == r) begin
                i_start    = 1'b1;
                i_key_last = alt_kl;
            end
            if (rdy && r == 1) got_rk1 = o_rk;
            if (rdy && r == 2) got_rk2 = o_rk;
            @(negedge clk);
            i_start    = 1'b0;
            i_key_last = '0;
            if (rdy) r--;
        end
        i_rk_ready = 1'b0;
        if (r >= 1) begin
            total++;
            bad++;
            $display("FAIL timeout: stuck at round %0d", r);
        end
        check("done_pulse", 80'(o_done),     80'd1);
        check("done_valid", 80'(o_rk_valid), 80'd0);
        @(negedge clk);
        check("done_once",  80'(o_done),     80'd0);
    endtask

    initial begin
        vec_t vecs [0:3];
        logic [63:0] k1, k2;

        vecs[0] = '{80'h0, 64'h0, 64'hC000_0000_0000_0000, 1'b1, 1'b0};
        vecs[1] = '{{80{1'b1}}, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        vecs[2] = '{80'h0123_4567_89AB_CDEF_0123, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0, 1'b1};
        vecs[3] = '{{80{1'b1}}, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};

        repeat (3) @(negedge clk);
        check_reset_outputs("rst_hold");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        for (int v = 0; v < 4; v++) begin
            run_seq(vecs[v].master, vecs[v].rnd, 0, 0, 80'd0, k1, k2);
            check("tbl_rk1", 80'(k1), 80'(vecs[v].rk1));
            if (vecs[v].chk2) check("tbl_rk2", 80'(k2), 80'(vecs[v].rk2));
        end

        // start during RUN must be ignored
        run_seq(80'hDEAD_BEEF_0000_1234_5678, 1'b0, 20, 0, 80'h1111_2222_3333_4444_5555, k1, k2);
        check("inj_rk1", 80'(k1), 80'h0000_DEAD_BEEF_0000_1234);

        // abort at round 10, then fresh key
        run_seq(80'hA5A5_5A5A_A5A5_5A5A_A5A5, 1'b0, 0, 10, 80'd0, k1, k2);
        check_reset_outputs("post_abort");
        run_seq(80'h0F0F_1E1E_2D2D_3C3C_4B4B, 1'b0, 0, 0, 80'd0, k1, k2);
        check("abort_new_rk1", 80'(k1), 80'h0000_0F0F_1E1E_2D2D_3C3C);

        // asynchronous reset mid-RUN
        build(80'h1234_5678_9ABC_DEF0_1357);
        @(negedge clk);
        i_key_last = st[31];
        i_start    = 1'b1;
        @(negedge clk);
        i_start    = 1'b0;
        i_rk_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("pre_rst_round", 80'(o_rk_round), 80'd27);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        i_rk_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("after_rst");
        run_seq(80'h1234_5678_9ABC_DEF0_1357, 1'b1, 0, 0, 80'd0, k1, k2);
        check("rst_rk1", 80'(k1), 80'h0000_1234_5678_9ABC_DEF0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
